// File: rtl/pio_key_pkg.sv
// Shared definitions for the PIO key interrupt master: FSM state encoding and
// the PIO register offsets it touches.
package pio_key_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD_EDGE,
    CAP_EDGE,
    CLR,
    RD_LVL,
    CAP_LVL,
    EMIT
  } state_t;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

endpackage

// File: rtl/pio_key_evt_cnt.sv
// Free-running 16-bit count of accepted key events; wraps FFFF -> 0.
module pio_key_evt_cnt (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/pio_key_irq_master.sv
// Avalon-MM master servicing a key PIO interrupt: read edge capture, clear it,
// read levels, emit one event. Define PIO_KEY_MASTER_COUNT_EN for evt_count.
module pio_key_irq_master
  import pio_key_pkg::*;
#(
  parameter int unsigned          KEY_W         = 4,
  parameter logic [KEY_W-1:0]     IRQ_MASK_INIT = 4'hF
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             irq_in,
  input  logic             enable,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [KEY_W-1:0] evt_edges,
  output logic [KEY_W-1:0] evt_level,
  output logic             busy,
  output logic [15:0]      evt_count
);

  state_t           state, state_nxt;
  logic [KEY_W-1:0] edges_q, level_q;
  logic             cs, wr_n;
  logic [1:0]       addr;
  logic [31:0]      wdata;
  logic             unused_rd;

  assign unused_rd = ^avm_readdata[31:KEY_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edges_q <= '0;
      level_q <= '0;
    end else begin
      if (state == CAP_EDGE) edges_q <= avm_readdata[KEY_W-1:0];
      if (state == CAP_LVL)  level_q <= avm_readdata[KEY_W-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    cs        = 1'b0;
    wr_n      = 1'b1;
    addr      = PIO_ADDR_DATA;
    wdata     = '0;
    case (state)
      INIT: begin
        cs        = 1'b1;
        wr_n      = 1'b0;
        addr      = PIO_ADDR_MASK;
        wdata     = 32'(IRQ_MASK_INIT);
        state_nxt = IDLE;
      end
      IDLE: begin
        if (irq_in && enable) state_nxt = RD_EDGE;
      end
      RD_EDGE: begin
        addr      = PIO_ADDR_EDGE;
        state_nxt = CAP_EDGE;
      end
      CAP_EDGE: begin
        // zero readback means a spurious interrupt: no clear, no event
        state_nxt = (avm_readdata[KEY_W-1:0] == '0) ? IDLE : CLR;
      end
      CLR: begin
        cs        = 1'b1;
        wr_n      = 1'b0;
        addr      = PIO_ADDR_EDGE;
        wdata     = 32'(edges_q);
        state_nxt = RD_LVL;
      end
      RD_LVL: begin
        addr      = PIO_ADDR_DATA;
        state_nxt = CAP_LVL;
      end
      CAP_LVL: state_nxt = EMIT;
      EMIT: begin
        if (evt_ready) state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  // State sits in INIT throughout reset, so the bus drive is masked by reset_n;
  // the INIT mask write is then taken by the PIO on the first edge after release.
  assign avm_chipselect = reset_n & cs;
  assign avm_write_n    = ~reset_n | wr_n;
  assign avm_address    = reset_n ? addr : PIO_ADDR_DATA;
  assign avm_writedata  = reset_n ? wdata : '0;

  assign evt_valid = (state == EMIT);
  assign evt_edges = edges_q;
  assign evt_level = level_q;
  assign busy      = (state != IDLE);

`ifdef PIO_KEY_MASTER_COUNT_EN
  pio_key_evt_cnt u_evt_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (evt_valid && evt_ready),
    .count   (evt_count)
  );
`else
  assign evt_count = '0;
`endif

endmodule

// File: tb/tb_pio_key_irq_master.sv
// Bench for pio_key_irq_master: behavioural PIO model, event scoreboard,
// vector table plus hand sequences for backpressure, enable and reset corners.
module tb_pio_key_irq_master;

  typedef struct packed {
    logic [3:0] edges;
    logic [3:0] level;
  } evt_t;

  typedef struct {
    logic [3:0] inj;
    logic [3:0] level;
    logic [3:0] exp_edges;
    logic [3:0] exp_level;
    int         exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_chipselect, avm_write_n;
  logic [31:0] avm_writedata, avm_readdata;
  logic        irq_in, enable, evt_valid, evt_ready, busy;
  logic [3:0]  evt_edges, evt_level;
  logic [15:0] evt_count;

  logic [3:0]  pio_edge, pio_mask, pio_level, inj_edge;
  logic        irq_force;

  int          n_checks = 0;
  int          n_pass = 0;
  int          wr_count = 0;
  int          acc_count = 0;
  logic [1:0]  last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic [15:0] exp_count = '0;
  evt_t        sb[$];

  always #5 clk = ~clk;

  pio_key_irq_master #(.KEY_W(4), .IRQ_MASK_INIT(4'hF)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .irq_in         (irq_in),
    .enable         (enable),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_edges      (evt_edges),
    .evt_level      (evt_level),
    .busy           (busy),
    .evt_count      (evt_count)
  );

  // PIO model: registered readdata, bit-clear edge capture, clear beats new edge
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_edge     <= '0;
      pio_mask     <= '0;
      avm_readdata <= '0;
    end else begin
      case (avm_address)
        2'd0:    avm_readdata <= {28'd0, pio_level};
        2'd2:    avm_readdata <= {28'd0, pio_mask};
        2'd3:    avm_readdata <= {28'd0, pio_edge};
        default: avm_readdata <= '0;
      endcase
      if (avm_chipselect && !avm_write_n && avm_address == 2'd2)
        pio_mask <= avm_writedata[3:0];
      if (avm_chipselect && !avm_write_n && avm_address == 2'd3)
        pio_edge <= (pio_edge | inj_edge) & ~avm_writedata[3:0];
      else
        pio_edge <= pio_edge | inj_edge;
    end
  end

  assign irq_in = (|(pio_edge & pio_mask)) | irq_force;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: bus writes, event scoreboard, running event count
  initial begin
    evt_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_count = '0;
        sb.delete();
      end else begin
        check("evt_count_run", 32'(evt_count), 32'(exp_count));
        if (avm_chipselect) begin
          wr_count++;
          last_wr_addr = avm_address;
          last_wr_data = avm_writedata;
          check("cs_with_write", 32'(avm_write_n), 32'd0);
        end
        if (evt_valid && evt_ready) begin
          acc_count++;
`ifdef PIO_KEY_MASTER_COUNT_EN
          exp_count = exp_count + 16'd1;
`endif
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got edges %b level %b, expected none", evt_edges, evt_level);
          end else begin
            e = sb.pop_front();
            check("sb_edges", 32'(evt_edges), 32'(e.edges));
            check("sb_level", 32'(evt_level), 32'(e.level));
          end
        end
      end
    end
  end

  task automatic inject(input logic [3:0] e);
    @(posedge clk); #1 inj_edge = e;
    @(posedge clk); #1 inj_edge = '0;
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 60 && sb.size() != 0; c++) @(negedge clk);
    check(name, 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vec_t vt[5];
    int   lat, w0, a0;
    bit   found, any_busy;

    enable    = 1'b1;
    evt_ready = 1'b1;
    inj_edge  = '0;
    irq_force = 1'b0;
    pio_level = '0;
    vt[0] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 7};
    vt[1] = '{4'b0001, 4'b1111, 4'b0001, 4'b1111, 7};
    vt[2] = '{4'b1010, 4'b0101, 4'b1010, 4'b0101, 7};
    vt[3] = '{4'b1111, 4'b1000, 4'b1111, 4'b1000, 7};
    vt[4] = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 7};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cs", 32'(avm_chipselect), 32'd0);
    check("rst_write_n", 32'(avm_write_n), 32'd1);
    check("rst_addr", 32'(avm_address), 32'd0);
    check("rst_wdata", avm_writedata, 32'd0);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_edges", 32'(evt_edges), 32'd0);
    check("rst_level", 32'(evt_level), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_count", 32'(evt_count), 32'd0);

    // INIT mask write on the first cycle after release
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("init_cs", 32'(avm_chipselect), 32'd1);
    check("init_write_n", 32'(avm_write_n), 32'd0);
    check("init_addr", 32'(avm_address), 32'd2);
    check("init_wdata", avm_writedata, 32'h0000000F);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_cs", 32'(avm_chipselect), 32'd0);
    check("init_mask", 32'(pio_mask), 32'hF);
    check("init_writes", 32'(wr_count), 32'd1);

    // table-driven services
    for (int i = 0; i < 5; i++) begin
      pio_level = vt[i].level;
      w0 = wr_count;
      a0 = acc_count;
      sb.push_back(evt_t'{edges: vt[i].exp_edges, level: vt[i].exp_level});
      inject(vt[i].inj);
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (evt_valid) begin
          lat = c;
          break;
        end
      end
      check("latency", 32'(lat), 32'(vt[i].exp_lat));
      repeat (3) @(negedge clk);
      check("vec_accepted", 32'(acc_count - a0), 32'd1);
      check("vec_writes", 32'(wr_count - w0), 32'd1);
      check("clr_addr", 32'(last_wr_addr), 32'd3);
      check("clr_data", last_wr_data, 32'(vt[i].exp_edges));
      check("edge_cleared", 32'(pio_edge), 32'd0);
      check("vec_idle", 32'(busy), 32'd0);
    end

    // spurious interrupt: edge readback zero
    w0 = wr_count;
    a0 = acc_count;
    @(posedge clk); #1 irq_force = 1'b1;
    @(posedge clk); #1 irq_force = 1'b0;
    @(negedge clk); check("spur_rd_edge", 32'(busy), 32'd1);
    @(negedge clk); check("spur_cap_edge", 32'(busy), 32'd1);
    @(negedge clk); check("spur_idle", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("spur_no_write", 32'(wr_count - w0), 32'd0);
    check("spur_no_event", 32'(acc_count - a0), 32'd0);

    // backpressure: 10 held cycles, an edge arriving meanwhile starts a new service
    w0 = wr_count;
    a0 = acc_count;
    evt_ready = 1'b0;
    pio_level = 4'b0011;
    sb.push_back(evt_t'{edges: 4'b0010, level: 4'b0011});
    inject(4'b0010);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (evt_valid) begin
        lat = c;
        break;
      end
    end
    check("bp_latency", 32'(lat), 32'd7);
    sb.push_back(evt_t'{edges: 4'b1000, level: 4'b0011});
    for (int h = 0; h < 10; h++) begin
      if (h > 0) @(negedge clk);
      check("hold_valid", 32'(evt_valid), 32'd1);
      check("hold_edges", 32'(evt_edges), 32'b0010);
      check("hold_level", 32'(evt_level), 32'b0011);
      if (h == 3) inj_edge = 4'b1000;
      if (h == 4) inj_edge = '0;
    end
    @(posedge clk); #1 evt_ready = 1'b1;
    @(negedge clk); check("bp_valid_11th", 32'(evt_valid), 32'd1);
    @(negedge clk); check("bp_back_idle", 32'(busy), 32'd0);
    @(negedge clk); check("bp_restart", 32'(busy), 32'd1);
    wait_drain("bp_drain");
    check("bp_accepted", 32'(acc_count - a0), 32'd2);
    check("bp_writes", 32'(wr_count - w0), 32'd2);
`ifdef PIO_KEY_MASTER_COUNT_EN
    check("count_after_bp", 32'(evt_count), 32'd7);
`else
    check("count_after_bp", 32'(evt_count), 32'd0);
`endif

    // enable dropped mid-service: service completes, no new one starts
    pio_level = 4'b0000;
    sb.push_back(evt_t'{edges: 4'b0100, level: 4'b0000});
    inject(4'b0100);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    wait_drain("en_drain");
    inject(4'b0001);
    any_busy = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy) any_busy = 1'b1;
    end
    check("en_no_start", 32'(any_busy), 32'd0);
    sb.push_back(evt_t'{edges: 4'b0001, level: 4'b0000});
    enable = 1'b1;
    wait_drain("en_resume");

    // reset asserted during CLR
    inject(4'b0001);
    found = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (avm_chipselect && avm_address == 2'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("found_clr", 32'(found), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_cs", 32'(avm_chipselect), 32'd0);
    check("mid_rst_write_n", 32'(avm_write_n), 32'd1);
    check("mid_rst_addr", 32'(avm_address), 32'd0);
    check("mid_rst_wdata", avm_writedata, 32'd0);
    check("mid_rst_valid", 32'(evt_valid), 32'd0);
    check("mid_rst_edges", 32'(evt_edges), 32'd0);
    check("mid_rst_level", 32'(evt_level), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_count", 32'(evt_count), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    w0 = wr_count;
    @(negedge clk);
    check("reinit_cs", 32'(avm_chipselect), 32'd1);
    check("reinit_addr", 32'(avm_address), 32'd2);
    check("reinit_wdata", avm_writedata, 32'h0000000F);
    @(negedge clk);
    check("reinit_once", 32'(wr_count - w0), 32'd1);
    check("reinit_idle", 32'(busy), 32'd0);

`ifdef PIO_KEY_MASTER_COUNT_EN
    // counter wrap FFFF -> 0
    @(posedge clk);
    #1 force dut.u_evt_cnt.count = 16'hFFFF;
    exp_count = 16'hFFFF;
    #1 release dut.u_evt_cnt.count;
    sb.push_back(evt_t'{edges: 4'b0100, level: 4'b0000});
    inject(4'b0100);
    wait_drain("wrap_drain");
    check("wrap_count", 32'(evt_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
